// File: rtl/seq_mult_cla_pkg.sv
// seq_mult_cla_pkg: FSM state encodings and operand-width legality check for seq_mult_cla.
package seq_mult_cla_pkg;
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic bit width_ok(input int w);
        return (w % 4 == 0) && (w >= 4) && (w <= 32);
    endfunction
endpackage

// File: rtl/seq_mult_cla_cla_adder_n.sv
// cla_adder_n: WIDTH-bit adder built from 4-bit carry-lookahead slices, rippling between slices.
module cla4 (
    input  logic [3:0] x,
    input  logic [3:0] y,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);
    logic [3:0] g, p;
    logic [3:1] c;
    assign g = x & y;
    assign p = x ^ y;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    assign cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & cin);
    assign sum = p ^ {c, cin};
endmodule

module cla_adder_n #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    logic [WIDTH/4:0] c;
    assign c[0] = cin;
    assign cout = c[WIDTH/4];
    for (genvar i = 0; i < WIDTH / 4; i++) begin : g_slice
        cla4 u_slice (
            .x   (x[4*i +: 4]),
            .y   (y[4*i +: 4]),
            .cin (c[i]),
            .sum (sum[4*i +: 4]),
            .cout(c[i+1])
        );
    end
endmodule

// File: rtl/seq_mult_cla.sv
// seq_mult_cla: ready/valid unsigned shift-and-add multiplier over a CLA chain.
// Optional SEQMUL_ZERO_SKIP_EN: zero operands bypass the iterations and finish right after accept.
module seq_mult_cla
    import seq_mult_cla_pkg::*;
#(
    parameter int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product
);
    if (!width_ok(WIDTH)) begin : g_bad_width
        $error("seq_mult_cla: WIDTH must be a multiple of 4 in 4..32");
    end

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] mcand, acc_hi, acc_lo, sum;
    logic [CNT_W-1:0] cnt;
    logic             cout;

    cla_adder_n #(.WIDTH(WIDTH)) u_add (
        .x   (acc_hi),
        .y   (acc_lo[0] ? mcand : '0),
        .cin (1'b0),
        .sum (sum),
        .cout(cout)
    );

    // The carry-out becomes the new top bit of acc_hi as the pair shifts right.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            product   <= '0;
            mcand     <= '0;
            acc_hi    <= '0;
            acc_lo    <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                ST_IDLE: if (in_valid) begin
                    mcand    <= a;
                    acc_hi   <= '0;
                    acc_lo   <= b;
                    cnt      <= '0;
                    in_ready <= 1'b0;
`ifdef SEQMUL_ZERO_SKIP_EN
                    if (a == '0 || b == '0) begin
                        state     <= ST_DONE;
                        product   <= '0;
                        out_valid <= 1'b1;
                    end else begin
                        state <= ST_RUN;
                    end
`else
                    state <= ST_RUN;
`endif
                end
                ST_RUN: begin
                    {acc_hi, acc_lo} <= {cout, sum, acc_lo[WIDTH-1:1]};
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state     <= ST_DONE;
                        product   <= {cout, sum, acc_lo[WIDTH-1:1]};
                        out_valid <= 1'b1;
                    end
                end
                ST_DONE: if (out_ready) begin
                    state     <= ST_IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
                default: begin
                    state     <= ST_IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_seq_mult_cla.sv
// tb_seq_mult_cla: directed vector table plus hand-written back-pressure, busy and reset sequences.
module tb_seq_mult_cla;
    localparam int W = 8;
`ifdef SEQMUL_ZERO_SKIP_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst, in_valid, in_ready, out_valid, out_ready;
    logic [W-1:0]   a, b;
    logic [2*W-1:0] product;
    int             n_checks = 0;
    int             n_fail = 0;

    seq_mult_cla #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .product  (product)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [2*W-1:0] p;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [W-1:0] xa, input logic [W-1:0] xb);
        int t = 0;
        while (!in_ready && t < 50) begin
            tick;
            t++;
        end
        check("issue_in_ready", 32'(in_ready), 32'd1);
        a = xa;
        b = xb;
        in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
    endtask

    task automatic wait_done(output int lat, output bit ir_bad);
        lat = 0;
        ir_bad = 1'b0;
        while (!out_valid && lat < 40) begin
            if (in_ready) ir_bad = 1'b1;
            tick;
            lat++;
        end
        check("done_within_budget", 32'(out_valid), 32'd1);
    endtask

    task automatic handoff;
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        check("handoff_out_valid", 32'(out_valid), 32'd0);
        check("handoff_in_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        vec_t vecs[7];
        int   lat, exp_lat;
        bit   ir_bad, stale;
        vecs[0] = '{a: 8'd13,  b: 8'd11,  p: 16'h008F};
        vecs[1] = '{a: 8'd255, b: 8'd255, p: 16'hFE01};
        vecs[2] = '{a: 8'd0,   b: 8'd77,  p: 16'h0000};
        vecs[3] = '{a: 8'd1,   b: 8'd1,   p: 16'h0001};
        vecs[4] = '{a: 8'd255, b: 8'd1,   p: 16'h00FF};
        vecs[5] = '{a: 8'd16,  b: 8'd16,  p: 16'h0100};
        vecs[6] = '{a: 8'd128, b: 8'd2,   p: 16'h0100};

        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        a = '0;
        b = '0;
        tick;
        tick;
        rst = 1'b0;
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_product", 32'(product), 32'd0);

        for (int i = 0; i < 7; i++) begin
            exp_lat = (SKIP && (vecs[i].a == 0 || vecs[i].b == 0)) ? 0 : W;
            issue(vecs[i].a, vecs[i].b);
            wait_done(lat, ir_bad);
            check($sformatf("vec%0d_product", i), 32'(product), 32'(vecs[i].p));
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(exp_lat));
            check($sformatf("vec%0d_in_ready_low_in_run", i), 32'(ir_bad), 32'd0);
            handoff;
        end

        issue(8'd200, 8'd3);
        wait_done(lat, ir_bad);
        for (int i = 0; i < 5; i++) begin
            tick;
            check("bp_product_held", 32'(product), 32'h0258);
            check("bp_out_valid_held", 32'(out_valid), 32'd1);
        end
        handoff;

        issue(8'd7, 8'd9);
        a = 8'd1;
        b = 8'd1;
        in_valid = 1'b1;
        wait_done(lat, ir_bad);
        check("busy_product", 32'(product), 32'h003F);
        check("busy_in_ready_low", 32'(ir_bad), 32'd0);
        handoff;
        tick;
        in_valid = 1'b0;
        check("busy_second_accepted", 32'(in_ready), 32'd0);
        wait_done(lat, ir_bad);
        check("busy_second_product", 32'(product), 32'h0001);
        handoff;

        issue(8'd100, 8'd100);
        tick;
        tick;
        tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd1);
        check("abort_product", 32'(product), 32'd0);
        stale = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick;
            if (out_valid) stale = 1'b1;
        end
        check("abort_no_stale_output", 32'(stale), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
